// File: rtl/bmc_soft_pipe.sv
// Soft-decision branch-metric unit for a rate-1/N trellis decoder: two-stage valid/ready pipeline.
// Optional build macro BMC_ERASURE_EN adds an in_erase port that zeroes erased bits' distances.
module bmc_soft_pipe #(
    parameter int unsigned N  = 2,
    parameter int unsigned SW = 3,
    localparam int unsigned MW = SW + $clog2(N),
    localparam int unsigned NH = 2 ** N
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [N*SW-1:0]   in_rx,
    input  logic              in_last,
`ifdef BMC_ERASURE_EN
    input  logic [N-1:0]      in_erase,
`endif
    output logic              out_valid,
    input  logic              out_ready,
    output logic [NH*MW-1:0]  out_bm,
    output logic              out_last,
    output logic [15:0]       sym_cnt
);

    logic [N*SW-1:0]  dist0, dist1;
    logic [NH*MW-1:0] sums;
    logic [MW-1:0]    acc;

    logic [N*SW-1:0]  s1_d0_q, s1_d0_d, s1_d1_q, s1_d1_d;
    logic             s1_valid_q, s1_valid_d, s1_last_q, s1_last_d;
    logic [NH*MW-1:0] s2_bm_q, s2_bm_d;
    logic             s2_valid_q, s2_valid_d, s2_last_q, s2_last_d;
    logic [15:0]      cnt_q, cnt_d;

    logic s1_load, s2_load, in_xfer, out_xfer;

    // Distance to a '1' is the bitwise complement of an offset-binary soft value.
    always_comb begin
        dist0 = '0;
        dist1 = '0;
        for (int i = 0; i < N; i++) begin
            dist0[i*SW +: SW] = in_rx[i*SW +: SW];
            dist1[i*SW +: SW] = ~in_rx[i*SW +: SW];
`ifdef BMC_ERASURE_EN
            if (in_erase[i]) begin
                dist0[i*SW +: SW] = '0;
                dist1[i*SW +: SW] = '0;
            end
`endif
        end
    end

    always_comb begin
        sums = '0;
        acc  = '0;
        for (int h = 0; h < NH; h++) begin
            acc = '0;
            for (int i = 0; i < N; i++) begin
                if (((h >> i) & 1) != 0) begin
                    acc = acc + MW'(s1_d1_q[i*SW +: SW]);
                end else begin
                    acc = acc + MW'(s1_d0_q[i*SW +: SW]);
                end
            end
            sums[h*MW +: MW] = acc;
        end
    end

    assign s2_load   = !s2_valid_q | out_ready;
    assign s1_load   = !s1_valid_q | s2_load;
    assign in_ready  = rst | s1_load;
    assign in_xfer   = in_valid & in_ready;
    assign out_xfer  = s2_valid_q & out_ready;

    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_d0_d    = s1_d0_q;
        s1_d1_d    = s1_d1_q;
        s1_last_d  = s1_last_q;
        s2_valid_d = s2_valid_q;
        s2_bm_d    = s2_bm_q;
        s2_last_d  = s2_last_q;
        cnt_d      = cnt_q;

        if (s1_load) begin
            s1_valid_d = in_valid;
        end
        if (in_xfer) begin
            s1_d0_d   = dist0;
            s1_d1_d   = dist1;
            s1_last_d = in_last;
        end

        if (s2_load) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                s2_bm_d   = sums;
                s2_last_d = s1_last_q;
            end
        end

        if (out_xfer) begin
            cnt_d = cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_d0_q    <= '0;
            s1_d1_q    <= '0;
            s1_last_q  <= 1'b0;
            s2_valid_q <= 1'b0;
            s2_bm_q    <= '0;
            s2_last_q  <= 1'b0;
            cnt_q      <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_d0_q    <= s1_d0_d;
            s1_d1_q    <= s1_d1_d;
            s1_last_q  <= s1_last_d;
            s2_valid_q <= s2_valid_d;
            s2_bm_q    <= s2_bm_d;
            s2_last_q  <= s2_last_d;
            cnt_q      <= cnt_d;
        end
    end

    assign out_valid = s2_valid_q;
    assign out_bm    = s2_bm_q;
    assign out_last  = s2_last_q;
    assign sym_cnt   = cnt_q;

endmodule

// File: tb/tb_bmc_soft_pipe.sv
// Directed bench for bmc_soft_pipe (N=2, SW=3 main instance plus an SW=1 hard-decision instance).
module tb_bmc_soft_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready, in_last;
    logic [5:0]  in_rx;
    logic        out_valid, out_ready, out_last;
    logic [15:0] out_bm;
    logic [15:0] sym_cnt;

    logic        h_in_valid, h_in_ready, h_in_last;
    logic [1:0]  h_in_rx;
    logic        h_out_valid, h_out_last;
    logic [7:0]  h_out_bm;
    logic [15:0] h_sym_cnt;

`ifdef BMC_ERASURE_EN
    logic [1:0]  in_erase;
    logic [1:0]  h_in_erase;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    bmc_soft_pipe #(.N(2), .SW(3)) u_dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_rx     (in_rx),
        .in_last   (in_last),
`ifdef BMC_ERASURE_EN
        .in_erase  (in_erase),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_bm    (out_bm),
        .out_last  (out_last),
        .sym_cnt   (sym_cnt)
    );

    bmc_soft_pipe #(.N(2), .SW(1)) u_hard (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (h_in_valid),
        .in_ready  (h_in_ready),
        .in_rx     (h_in_rx),
        .in_last   (h_in_last),
`ifdef BMC_ERASURE_EN
        .in_erase  (h_in_erase),
`endif
        .out_valid (h_out_valid),
        .out_ready (1'b1),
        .out_bm    (h_out_bm),
        .out_last  (h_out_last),
        .sym_cnt   (h_sym_cnt)
    );

    typedef struct {
        logic [2:0]  rx0;
        logic [2:0]  rx1;
        logic        last;
        logic [15:0] bm;
    } vec_t;

    vec_t vecs [5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    // Independent reference: distance to '1' computed as 7 - r.
    function automatic logic [15:0] model_bm(input int r0, input int r1);
        logic [15:0] m;
        int s;
        m = '0;
        for (int h = 0; h < 4; h++) begin
            s = (((h & 1) != 0) ? (7 - r0) : r0) + (((h & 2) != 0) ? (7 - r1) : r1);
            m[h*4 +: 4] = 4'(s);
        end
        return m;
    endfunction

    task automatic send_one(input string name, input logic [2:0] r0, input logic [2:0] r1,
                            input logic last, input logic [15:0] exp);
        @(negedge clk);
        in_valid = 1'b1;
        in_rx    = {r1, r0};
        in_last  = last;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check({name, " latency1 out_valid"}, 32'(out_valid), 32'd0);
        @(posedge clk);
        #1;
        check({name, " out_valid"}, 32'(out_valid), 32'd1);
        check({name, " out_bm"}, 32'(out_bm), 32'(exp));
        check({name, " out_last"}, 32'(out_last), 32'(last));
    endtask

    initial begin
        int sent, got, cyc;
        logic acc, ovk, held, held_last;
        logic [15:0] held_bm;

        vecs[0] = '{rx0: 3'd7, rx1: 3'd7, last: 1'b0, bm: 16'h077E};
        vecs[1] = '{rx0: 3'd0, rx1: 3'd7, last: 1'b0, bm: 16'h70E7};
        vecs[2] = '{rx0: 3'd3, rx1: 3'd5, last: 1'b1, bm: 16'h6598};
        vecs[3] = '{rx0: 3'd0, rx1: 3'd0, last: 1'b0, bm: 16'hE770};
        vecs[4] = '{rx0: 3'd2, rx1: 3'd6, last: 1'b0, bm: 16'h63B8};

        rst = 1'b1;
        in_valid = 1'b0;
        in_rx = '0;
        in_last = 1'b0;
        out_ready = 1'b1;
        h_in_valid = 1'b0;
        h_in_rx = '0;
        h_in_last = 1'b0;
`ifdef BMC_ERASURE_EN
        in_erase = '0;
        h_in_erase = '0;
`endif
        repeat (2) @(posedge clk);
        #1;
        check("reset out_valid", 32'(out_valid), 32'd0);
        check("reset out_bm", 32'(out_bm), 32'd0);
        check("reset out_last", 32'(out_last), 32'd0);
        check("reset sym_cnt", 32'(sym_cnt), 32'd0);
        check("reset in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 5; i++) begin
            send_one($sformatf("vec%0d", i), vecs[i].rx0, vecs[i].rx1, vecs[i].last, vecs[i].bm);
        end
        @(posedge clk);
        #1;
        check("table sym_cnt", 32'(sym_cnt), 32'd5);

        // Hard decision, rx0=1 rx1=0.
        @(negedge clk);
        h_in_valid = 1'b1;
        h_in_rx    = 2'b01;
        @(posedge clk);
        #1;
        h_in_valid = 1'b0;
        @(posedge clk);
        #1;
        check("hard out_valid", 32'(h_out_valid), 32'd1);
        check("hard out_bm", 32'(h_out_bm), 32'h61);

`ifdef BMC_ERASURE_EN
        @(negedge clk);
        in_erase = 2'b10;
        send_one("erase", 3'd7, 3'd3, 1'b0, 16'h0707);
        in_erase = 2'b00;
`endif

        // Fill both stages with the output stalled, then pulse reset.
        @(negedge clk);
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_rx     = {3'd1, 3'd2};
        in_last   = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("full out_valid", 32'(out_valid), 32'd1);
        check("full in_ready stalled", 32'(in_ready), 32'd0);
        out_ready = 1'b1;
        #1;
        check("full in_ready from out_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        out_ready = 1'b0;
        rst = 1'b1;
        #1;
        check("in_ready during rst", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        check("post-rst out_valid", 32'(out_valid), 32'd0);
        check("post-rst sym_cnt", 32'(sym_cnt), 32'd0);
        check("post-rst out_bm", 32'(out_bm), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        in_valid = 1'b0;
        in_last = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            check($sformatf("no stale output %0d", i), 32'(out_valid), 32'd0);
        end

        // 20 back-to-back symbols, random out_ready, last on the 5th.
        sent = 0;
        got = 0;
        for (cyc = 0; cyc < 400 && got < 20; cyc++) begin
            @(negedge clk);
            out_ready = 1'($urandom_range(0, 1));
            if (sent < 20) begin
                in_valid = 1'b1;
                in_rx    = {3'((sent * 5 + 1) % 8), 3'((sent * 3) % 8)};
                in_last  = (sent == 4);
            end else begin
                in_valid = 1'b0;
            end
            #1;
            acc = in_valid & in_ready;
            ovk = out_valid & out_ready;
            if (ovk) begin
                check($sformatf("stream bm %0d", got), 32'(out_bm),
                      32'(model_bm((got * 3) % 8, (got * 5 + 1) % 8)));
                check($sformatf("stream last %0d", got), 32'(out_last), 32'(got == 4));
                got++;
            end
            held      = out_valid & !out_ready;
            held_bm   = out_bm;
            held_last = out_last;
            @(posedge clk);
            #1;
            if (acc) sent++;
            if (held) begin
                check("stall out_valid held", 32'(out_valid), 32'd1);
                check("stall out_bm held", 32'(out_bm), 32'(held_bm));
                check("stall out_last held", 32'(out_last), 32'(held_last));
            end
        end
        check("stream output count", 32'(got), 32'd20);
        check("stream sym_cnt", 32'(sym_cnt), 32'd20);

        // Stream until the counter reaches its maximum, then watch it wrap.
        @(negedge clk);
        in_valid = 1'b1;
        in_last = 1'b0;
        out_ready = 1'b1;
        cyc = 0;
        while (sym_cnt !== 16'hFFFF && cyc < 70000) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        check("sym_cnt reaches 65535", 32'(sym_cnt), 32'hFFFF);
        @(posedge clk);
        #1;
        check("sym_cnt wraps to 0", 32'(sym_cnt), 32'd0);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(posedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/bmc_soft_pipe.md
BMC_SOFT_PIPE -- requirements
Module: bmc_soft_pipe

Interface
REQ-001 SHALL have parameter N, default 2: code bits per trellis symbol (rate 1/N), legal 2..4.
REQ-002 SHALL have parameter SW, default 3: soft-bit width, legal 1..4; SW=1 is hard decision.
REQ-003 SHALL have derived localparam MW = SW + clog2(N): branch-metric width.
REQ-004 SHALL have port clk, input, 1: single clock, all logic on rising edge.
REQ-005 SHALL have port rst, input, 1: reset, synchronous, active-high.
REQ-006 SHALL have port in_valid, input, 1: received symbol present.
REQ-007 SHALL have port in_ready, output, 1: block accepts symbol this cycle.
REQ-008 SHALL have port in_rx, input, N*SW: soft bit i at [i*SW +: SW], unsigned offset-binary, 0 = strongest '0', 2^SW-1 = strongest '1'.
REQ-009 SHALL have port in_last, input, 1: tag for the final symbol of a block, carried alongside the data.
REQ-010 SHALL have port out_valid, output, 1: metrics valid.
REQ-011 SHALL have port out_ready, input, 1: downstream accepts.
REQ-012 SHALL have port out_bm, output, (2^N)*MW: metric for hypothesis h at [h*MW +: MW]; bit i of h is the expected code bit i.
REQ-013 SHALL have port out_last, output, 1: in_last of the symbol currently presented.
REQ-014 SHALL have port sym_cnt, output, 16: count of output transfers, wraps 65535 -> 0.

Function
REQ-015 SHALL compute per-bit distance d(r,0) = r and d(r,1) = (2^SW-1) - r.
REQ-016 SHALL compute out_bm[h] as the sum over i of d(rx_i, h[i]), zero-extended to MW bits; no saturation is required because the maximum is N*(2^SW-1).
REQ-017 SHALL be a two-stage pipeline: S1 registers all 2N per-bit distances plus last; S2 registers all 2^N sums plus last.
REQ-018 SHALL present a symbol accepted at edge k on out_bm at edge k+2 when out_ready is held high; sustained throughput SHALL be 1 symbol/cycle.
REQ-019 SHALL define input transfer as in_valid & in_ready, and output transfer as out_valid & out_ready.
REQ-020 SHALL load S2 when !s2_valid | out_ready.
REQ-021 SHALL load S1 when !s1_valid | s2_load.
REQ-022 SHALL drive in_ready = !s1_valid | s2_load; this is a combinational path from out_ready, and a bubble-free stall is required.
REQ-023 SHALL hold out_bm and out_last stable while out_valid & !out_ready.
REQ-024 SHALL never drop, duplicate or reorder symbols under any in_valid/out_ready pattern.
REQ-025 SHALL increment sym_cnt by 1 on each output transfer.
REQ-026 SHALL ignore in_rx and in_last when no input transfer occurs.

Reset
REQ-027 SHALL, while rst=1 at an edge, clear s1_valid, s2_valid and sym_cnt; out_valid=0, out_last=0, out_bm=0.
REQ-028 SHALL discard any in-flight symbols when reset is asserted mid-stream; the first post-reset output is the first symbol accepted after rst deasserts.
REQ-029 SHALL drive in_ready=1 during and after reset; a transfer in a cycle where rst=1 is discarded.

Configuration
REQ-030 SHALL, with macro BMC_ERASURE_EN defined, add input in_erase (N bits, sampled with in_rx) and make an erased bit i contribute 0 to every hypothesis, for depuncturing.
REQ-031 SHALL, without BMC_ERASURE_EN, omit the in_erase port so that every bit contributes per REQ-015; the pipeline and latency are identical in both builds.

Verification (N=2, SW=3 unless stated)
REQ-032 SHALL verify: rx0=7, rx1=7 -> bm[0]=14, bm[1]=7, bm[2]=7, bm[3]=0, appearing 2 cycles after acceptance.
REQ-033 SHALL verify: rx0=0, rx1=7 -> bm[0]=7, bm[1]=14, bm[2]=0, bm[3]=7; and SW=1, rx=(1,0) -> bm = {0:1, 1:0, 2:2, 3:1}.
REQ-034 SHALL verify: 20 back-to-back symbols with random out_ready (50%) -> all 20 outputs in order, out_bm stable while stalled, sym_cnt=20.
REQ-035 SHALL verify: rst pulsed for 1 cycle with both stages full -> out_valid=0 next cycle, sym_cnt=0, no stale output afterwards.
REQ-036 SHALL verify, with BMC_ERASURE_EN: rx0=7, in_erase=2'b10 -> bm[0]=7, bm[1]=0, bm[2]=7, bm[3]=0.
REQ-037 SHALL verify: in_last=1 on the 5th symbol -> out_last=1 only with the 5th output; sym_cnt preloaded near 65535 wraps to 0.
